// File: rtl/dec_digit_serializer_64.sv
// dec_digit_serializer_64: sequential 64-bit binary to decimal converter.
// Produces one digit per cycle during conversion, using v/10 = (v>>1)/5.
// Digits are stored least significant first and then streamed most
// significant first over a valid/ready interface.

// div_64_5: combinational unsigned divide-by-5 by reciprocal multiplication.
module div_64_5 (
    input  logic [63:0] dividend,
    output logic [61:0] quotient
);
    logic [127:0] product;
    logic [65:0]  unused_frac;

    // floor(x/5) == floor(x * ceil(2^66/5) / 2^66) holds for every 64-bit x
    always_comb begin
        product     = {64'd0, dividend} * {64'd0, 64'hCCCC_CCCC_CCCC_CCCD};
        quotient    = product[127:66];
        unused_frac = product[65:0];
    end
endmodule

module dec_digit_serializer_64 #(
    parameter int unsigned PAD20 = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_digit,
    output logic [4:0]  out_index,
    output logic        out_last,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, CONV, EMIT} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [63:0] v;
    logic [4:0]  cnt;
    logic [3:0]  dig_buf [20];

    logic [61:0] q_narrow;
    logic [63:0] q;
    logic [63:0] ten_q;
    logic [63:0] rem;
    logic [3:0]  d;
    logic        conv_done;
    logic [59:0] unused_rem_hi;

    div_64_5 u_div (
        .dividend ({1'b0, v[63:1]}),
        .quotient (q_narrow)
    );

    // One decimal step: quotient, remainder digit and conversion-done flag
    always_comb begin
        q             = {2'b00, q_narrow};
        ten_q         = (q << 3) + (q << 1);
        rem           = v - ten_q;
        d             = rem[3:0];
        unused_rem_hi = rem[63:4];
        if (PAD20 != 0) begin
            conv_done = (cnt == 5'd19);
        end else begin
            conv_done = (q == '0);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = CONV;
            CONV:    if (conv_done) state_nxt = EMIT;
            EMIT:    if (out_ready && out_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == EMIT);
    assign busy      = (state != IDLE);

    // Working value, digit count and registered output digit/position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v         <= '0;
            cnt       <= '0;
            out_digit <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        v   <= in_data;
                        cnt <= '0;
                    end
                end
                CONV: begin
                    v   <= q;
                    cnt <= cnt + 5'd1;
                    // The most significant digit is loaded straight from the
                    // divider so it is on out_digit the first EMIT cycle.
                    if (conv_done) begin
                        out_index <= cnt;
                        out_digit <= d;
                        out_last  <= (cnt == 5'd0);
                    end
                end
                EMIT: begin
                    if (out_ready && !out_last) begin
                        out_index <= out_index - 5'd1;
                        out_digit <= dig_buf[out_index - 5'd1];
                        out_last  <= (out_index == 5'd1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Digit buffer, least significant digit at index 0
    always_ff @(posedge clk) begin
        if (state == CONV) begin
            dig_buf[cnt] <= d;
        end
    end
endmodule

// File: doc/dec_digit_serializer_64.md
# dec_digit_serializer_64

Sequential 64-bit binary-to-decimal converter placed directly downstream of the constant-division datapath. It instantiates `div_64_5` combinationally and produces one decimal digit per clock: v/10 = (v>>1)/5, and the remainder is v − 10·q. Digits are buffered least significant first, then streamed most significant first over a valid/ready interface for the formatting and output logic.

## Interface
- `PAD20`, default 0: 0 emits digits with leading zeros suppressed (at least one digit); 1 always emits exactly 20 digits.
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: block is idle and can accept a value.
- `in_data` in 64: unsigned binary value to convert.
- `out_valid` out 1: `out_digit` is valid.
- `out_ready` in 1: consumer accepts the digit.
- `out_digit` out 4: BCD digit, 0–9.
- `out_index` out 5: decimal position of the current digit; 0 is the least significant.
- `out_last` out 1: current digit is position 0.
- `busy` out 1: block is in state CONV or EMIT.

## Operation
- **States:** IDLE, CONV, EMIT.
- **Reset values:** state=IDLE; `in_ready`=1; `out_valid`=0; `out_digit`=0; `out_index`=0; `out_last`=0; `busy`=0; digit count=0.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: v ← `in_data`; cnt ← 0; go to CONV.
  - `in_data` is ignored when there is no handshake.
- **CONV, one digit per cycle:**
  - q = div_64_5(v>>1) (Q zero-extended to 64 bits).
  - d = (v − 10·q)[3:0]; d must be ≤ 9.
  - buf[cnt] ← d; v ← q; cnt ← cnt+1.
  - 10·q is computed as (q<<3)+(q<<1) in 64 bits.
- **CONV exit:**
  - PAD20=0: leave CONV after the cycle in which the new v is 0. N = cnt after that cycle, 1 ≤ N ≤ 20. An input of 0 gives N=1 with digit 0.
  - PAD20=1: leave after exactly 20 CONV cycles; N=20. Upper buffer entries hold 0.
- **EMIT:**
  - `out_valid`=1; `out_index`=p, starting at N−1; `out_digit`=buf[p]; `out_last`=(p==0).
  - On `out_valid`&&`out_ready`: p ← p−1.
  - On the handshake where `out_last`=1: go to IDLE.
- **Backpressure:** while `out_ready`=0, `out_digit`, `out_index` and `out_last` stay stable and `out_valid` stays 1.
- `in_ready`=0 in CONV and EMIT. Inputs offered there are not accepted and not lost; the upstream holds them.
- **Reset mid-operation:** immediately returns to IDLE with reset values; the partially converted value is discarded and nothing more is emitted.

## Timing
- **Accept:** cycle 0, the `in_valid`&&`in_ready` edge.
- **Conversion:** CONV occupies cycles 1..N.
- **First digit:** `out_valid` rises in cycle N+1.
- **Zero-stall case:** EMIT lasts N cycles. `in_ready` returns to 1 in the cycle after the last handshake, which is cycle 2N+1.
- **Throughput:** one value per 2N+1 cycles, with no overlap of conversion and emission.
- **Critical path:** div_64_5 plus the 64-bit multiply-by-10 subtract, in a single cycle. No pipeline registers inside CONV.
- **Outputs:** all outputs are registered or decoded directly from state. No combinational path from `out_ready` or `in_valid` to any output.

## Test plan
- **Zero input, PAD20=0:** `in_data`=0 → one digit: `out_digit`=0, `out_index`=0, `out_last`=1; `out_valid` first high in cycle 2 after accept.
- **Typical value:** `in_data`=12345, `out_ready`=1 → digits 1,2,3,4,5 with `out_index` 4..0; `out_last` only on 5; `out_valid` first in cycle 6; `in_ready` again in cycle 11.
- **Maximum value:** `in_data`=2^64−1 → 20 digits "18446744073709551615"; also 10^19 → "10000000000000000000"; also 9999999999 → ten 9s.
- **Backpressure:** 9876 with `out_ready` toggling pseudo-randomly → digit sequence 9,8,7,6 unchanged; outputs stable on every stalled cycle; `in_valid` held during busy is not accepted until IDLE.
- **PAD20=1:** 7 → 19 zeros (`out_index` 19..1), then 7 with `out_last`; CONV lasts exactly 20 cycles.
- **Reset mid-EMIT:** assert `rst_n`=0 after 2 of 5 digits of 12345 are handshaken → `out_valid`=0 and `in_ready`=1 immediately. Then send 42 → exactly 4,2 emitted.
- **Randomized check:** 10^4 random 64-bit values back-to-back → emitted string matches a decimal reference model, and d ≤ 9 holds every CONV cycle.
